divider_seq: RTL and testbench
==============================

DIVIDER_SEQ -- requirements
Module: divider_seq

Interface
REQ-001 SHALL have port: clock  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port: reset_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port: start  input  1  request a new divide, sampled on rising clock.
REQ-004 SHALL have port: A  input  8  unsigned dividend, captured when start is accepted.
REQ-005 SHALL have port: B  input  8  unsigned divisor, captured when start is accepted.
REQ-006 SHALL have port: Q  output  8  unsigned quotient, registered.
REQ-007 SHALL have port: R  output  8  unsigned remainder, registered.
REQ-008 SHALL have port: complete  output  1  one-cycle pulse, result valid.
REQ-009 SHALL have port: busy  output  1  high while a divide is in progress.
REQ-010 SHALL have port: div_by_zero  output  1  high with complete when captured B was 0; held until next accepted start.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-012 SHALL accept start only in IDLE or DONE; start in RUN is ignored, with no effect on operands, counter or outputs.
REQ-013 On an accepted start at edge N: latch A and B; clear working remainder; load working quotient with A; clear 3-bit iteration counter; clear div_by_zero.
REQ-014 On an accepted start with B != 0: enter RUN at edge N.
REQ-015 On an accepted start with B == 0: enter DONE at edge N; set Q=8'hFF, R=A, div_by_zero=1.
REQ-016 RUN SHALL perform one restoring-division step per cycle at edges N+1..N+8.
- Step: shift the 16-bit {rem, quo} left by 1.
- Compare using a 9-bit remainder so no overflow is lost.
- If the shifted remainder >= latched B: subtract B and set quo[0]=1; else set quo[0]=0.
REQ-017 After the 8th step (edge N+8): load Q from quo and R from rem; enter DONE; counter wraps to 0.
REQ-018 complete SHALL be 1 exactly during the single cycle the FSM is in DONE; 0 otherwise.
REQ-019 Latency: start accepted at edge N -> complete high after edge N+8 (B != 0) or after edge N+1... corrected: after edge N (B == 0), visible in the following cycle.
REQ-020 busy SHALL be 1 exactly while in RUN; busy and complete are never 1 together.
REQ-021 From DONE, the next edge SHALL go to IDLE unless start=1, in which case REQ-013..015 apply (back-to-back divides, no idle cycle).
REQ-022 Q, R and div_by_zero SHALL hold their values through IDLE until the next result load; they are not updated during RUN.
REQ-023 Changes on A/B after capture SHALL NOT affect the result in progress.
REQ-024 All arithmetic is unsigned; Q*B+R == A and R < B for every B != 0.

Reset
REQ-025 reset_n=0 SHALL immediately, regardless of clock, force state=IDLE, Q=0, R=0, complete=0, busy=0, div_by_zero=0, counter=0.
REQ-026 Reset asserted mid-RUN SHALL abort the divide with no complete pulse; the first rising edge after release with start=1 begins a fresh divide.
REQ-027 start SHALL be ignored on any edge while reset_n=0.

Verification
REQ-028 A=100, B=7, start at edge N -> busy at N+1..N+8, complete pulse after N+8, Q=14, R=2, div_by_zero=0.
REQ-029 A=255, B=1 -> Q=255, R=0; then A=5, B=9 -> Q=0, R=5.
REQ-030 A=0x2A, B=0 -> complete in the cycle after edge N, Q=0xFF, R=0x2A, div_by_zero=1, busy never asserted.
REQ-031 A=200, B=3 with start re-asserted and A/B changed at N+3 -> request ignored, result Q=66, R=2 at N+8, single complete pulse.
REQ-032 Start asserted in the DONE cycle with A=9, B=4 -> no IDLE cycle, new complete 8 edges later, Q=2, R=1.
REQ-033 reset_n pulsed low at N+4 of a divide -> all outputs 0 immediately, no complete; a subsequent divide 50/5 returns Q=10, R=0.

Source files
------------

// File: rtl/divider_seq.sv
// divider_seq: 8-bit unsigned restoring divider, one quotient bit per clock.
// A start accepted in IDLE or DONE captures the operands. A zero divisor is
// answered at once through DONE. Any other divisor runs eight RUN steps and
// then loads Q and R. Q, R and div_by_zero hold between results.
module divider_seq (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [7:0] Q,
    output logic [7:0] R,
    output logic       complete,
    output logic       busy,
    output logic       div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  b_q, b_d;
    logic [7:0]  rem_q, rem_d;
    logic [7:0]  quo_q, quo_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  q_q, q_d;
    logic [7:0]  r_q, r_d;
    logic        dbz_q, dbz_d;
    logic        busy_q, busy_d;
    logic        cmpl_q, cmpl_d;

    // Datapath for one restoring step.
    // The shifted remainder is 9 bits wide so that the carry out of rem is kept for the compare.
    // After a subtract the value is below B, so the low 8 bits are the exact remainder.
    logic [8:0]  rem_sh_s;
    logic        ge_s;
    logic [7:0]  rem_step_s;
    logic [7:0]  quo_step_s;

    // One restoring-division step computed from the current working registers
    always_comb begin
        rem_sh_s   = {rem_q, quo_q[7]};
        ge_s       = (rem_sh_s >= {1'b0, b_q});
        if (ge_s) begin
            rem_step_s = rem_sh_s[7:0] - b_q;
        end else begin
            rem_step_s = rem_sh_s[7:0];
        end
        quo_step_s = {quo_q[6:0], ge_s};
    end

    // Next-state and next-register logic; everything holds unless updated below
    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    b_d   = B;
                    rem_d = 8'd0;
                    quo_d = A;
                    cnt_d = 3'd0;
                    dbz_d = 1'b0;
                    if (B == 8'd0) begin
                        state_d = DONE;
                        q_d     = 8'hFF;
                        r_d     = A;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                rem_d = rem_step_s;
                quo_d = quo_step_s;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    q_d     = quo_step_s;
                    r_d     = rem_step_s;
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
        cmpl_d = (state_d == DONE);
    end

    // State, working and output registers with asynchronous clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            b_q     <= 8'd0;
            rem_q   <= 8'd0;
            quo_q   <= 8'd0;
            cnt_q   <= 3'd0;
            q_q     <= 8'd0;
            r_q     <= 8'd0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            cmpl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            cmpl_q  <= cmpl_d;
        end
    end

    assign Q           = q_q;
    assign R           = r_q;
    assign complete    = cmpl_q;
    assign busy        = busy_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq.
// Results are compared with plain '/' and '%' arithmetic.
// The bench covers directed corner cases, mid-run restarts, reset aborts and random divides.
module tb_divider_seq;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] Q;
    logic [7:0] R;
    logic       complete;
    logic       busy;
    logic       div_by_zero;

    int checks;
    int errors;

    divider_seq dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .A           (A),
        .B           (B),
        .Q           (Q),
        .R           (R),
        .complete    (complete),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Must be called at a negedge.
    // Drives one start, then waits for complete.
    // When inject_k >= 0, a second start carrying junk operands is driven toward edge N+inject_k+1.
    // Returns at the negedge of the DONE cycle.
    task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input int inject_k);
        logic [7:0] exp_q;
        logic [7:0] exp_r;
        int         exp_lat;
        int         k;
        exp_q   = (b == 8'd0) ? 8'hFF : 8'(a / b);
        exp_r   = (b == 8'd0) ? a : 8'(a % b);
        exp_lat = (b == 8'd0) ? 0 : 8;
        start = 1'b1;
        A     = a;
        B     = b;
        @(negedge clock);
        start = 1'b0;
        A     = 8'($urandom);
        B     = 8'($urandom);
        k = 0;
        while (!complete && k < 20) begin
            check_eq({tag, " busy"}, {31'd0, busy}, {31'd0, (b != 8'd0)});
            if (k == inject_k) begin
                start = 1'b1;
                A     = 8'd1;
                B     = 8'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            k++;
        end
        start = 1'b0;
        check_eq({tag, " latency"}, k, exp_lat);
        check_eq({tag, " Q"}, {24'd0, Q}, {24'd0, exp_q});
        check_eq({tag, " R"}, {24'd0, R}, {24'd0, exp_r});
        check_eq({tag, " dbz"}, {31'd0, div_by_zero}, {31'd0, (b == 8'd0)});
        check_eq({tag, " busy_in_done"}, {31'd0, busy}, 32'd0);
    endtask

    // One cycle in IDLE after a result: complete drops and the outputs hold
    task automatic idle_check(input string tag, input logic [7:0] eq, input logic [7:0] er,
                              input logic edz);
        @(negedge clock);
        check_eq({tag, " pulse"}, {31'd0, complete}, 32'd0);
        check_eq({tag, " hold"}, {15'd0, Q, R, div_by_zero}, {15'd0, eq, er, edz});
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        start   = 1'b0;
        A       = 8'd0;
        B       = 8'd0;
        @(negedge clock);
        check_eq("reset outs", {20'd0, Q, R, complete, busy, div_by_zero, 1'b0},
                 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        run_div("100/7", 8'd100, 8'd7, -1);
        idle_check("100/7 idle", 8'd14, 8'd2, 1'b0);
        run_div("255/1", 8'd255, 8'd1, -1);
        idle_check("255/1 idle", 8'd255, 8'd0, 1'b0);
        run_div("5/9", 8'd5, 8'd9, -1);
        idle_check("5/9 idle", 8'd0, 8'd5, 1'b0);
        run_div("2A/0", 8'h2A, 8'd0, -1);
        idle_check("2A/0 idle", 8'hFF, 8'h2A, 1'b1);
        run_div("200/3 restart", 8'd200, 8'd3, 2);
        idle_check("200/3 idle", 8'd66, 8'd2, 1'b0);

        // Back-to-back: the second start is driven during the DONE cycle
        run_div("b2b first", 8'd77, 8'd10, -1);
        run_div("9/4 b2b", 8'd9, 8'd4, -1);
        idle_check("9/4 idle", 8'd2, 8'd1, 1'b0);

        // Reset pulsed in the middle of a divide
        start = 1'b1;
        A     = 8'd100;
        B     = 8'd7;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async reset outs", {20'd0, Q, R, complete, busy, div_by_zero, 1'b0},
                 32'd0);
        start = 1'b1;
        A     = 8'd50;
        B     = 8'd5;
        @(negedge clock);
        check_eq("start in reset", {29'd0, complete, busy, div_by_zero}, 32'd0);
        start   = 1'b0;
        reset_n = 1'b1;
        repeat (10) begin
            @(negedge clock);
            check_eq("no complete after abort", {30'd0, complete, busy}, 32'd0);
        end
        run_div("50/5", 8'd50, 8'd5, -1);
        idle_check("50/5 idle", 8'd10, 8'd0, 1'b0);

        // Random divides, roughly one in eight with a zero divisor
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            run_div("rand", ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1);
            idle_check("rand idle", (rb == 8'd0) ? 8'hFF : 8'(ra / rb),
                       (rb == 8'd0) ? ra : 8'(ra % rb), (rb == 8'd0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
